// File: rtl/me_unit_pkg.sv
// me_unit_pkg -- shared geometry, state codes and address helpers for the motion estimator.
// Rev 1.0
`default_nettype none

package me_unit_pkg;

  localparam int BLK   = 8;
  localparam int WIN   = 32;
  localparam int NPOS  = 25;
  localparam int SAD_W = 14;

  localparam logic [SAD_W-1:0] SAD_INIT = 14'h3FFF;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_CUR = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_ACC      = 3'd3;
  localparam logic [2:0] S_CMP      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Word address of half `half` of current-block row `row`: 2*row + half.
  function automatic logic [31:0] cur_addr(input logic [2:0] row, input logic half);
    return {28'd0, row, half};
  endfunction

  // Word address of word `w` of reference-window row `row`: 4*row + w.
  function automatic logic [31:0] ref_addr(input logic [4:0] row, input logic [1:0] w);
    return {25'd0, row, w};
  endfunction

endpackage

`default_nettype wire

// File: rtl/me_unit_if.sv
// me_unit_if -- start request, memory read ports and result bus of the motion estimator.
// Rev 1.0
`default_nettype none

interface me_unit_if;
  import me_unit_pkg::*;

  logic             en_i;
  logic [31:0]      cur_in_i;
  logic [63:0]      ref_in_i;
  logic [31:0]      cur_mem_addr;
  logic [31:0]      ref_mem_addr;
  logic             cur_mem_en;
  logic             ref_mem_en;
  logic [SAD_W-1:0] MSAD;
  logic [4:0]       MSAD_row;
  logic [4:0]       MSAD_column;
  logic             data_valid;

  modport master (
    output en_i, cur_in_i, ref_in_i,
    input  cur_mem_addr, ref_mem_addr, cur_mem_en, ref_mem_en,
    input  MSAD, MSAD_row, MSAD_column, data_valid
  );

  modport slave (
    input  en_i, cur_in_i, ref_in_i,
    output cur_mem_addr, ref_mem_addr, cur_mem_en, ref_mem_en,
    output MSAD, MSAD_row, MSAD_column, data_valid
  );

endinterface

`default_nettype wire

// File: rtl/me_unit_sad_row8.sv
// sad_row8 -- combinational sum of absolute differences over one 8-pixel row.
// Rev 1.0
`default_nettype none

module sad_row8
  import me_unit_pkg::*;
(
  input  logic [63:0] i_cur,
  input  logic [63:0] i_ref,
  output logic [10:0] o_sad
);

  always_comb begin
    o_sad = '0;
    for (int j = 0; j < BLK; j++) begin
      o_sad = o_sad + 11'((i_cur[8*j +: 8] > i_ref[8*j +: 8]) ?
                          (i_cur[8*j +: 8] - i_ref[8*j +: 8]) :
                          (i_ref[8*j +: 8] - i_cur[8*j +: 8]));
    end
  end

endmodule

`default_nettype wire

// File: rtl/me_unit.sv
// me_unit -- full-search 8x8 block matcher over a 32x32 window, one reference row per 5 cycles.
// Rev 1.0
`default_nettype none

module me_unit
  import me_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  me_unit_if.slave    bus
);

  logic [2:0]       r_state;
  logic [3:0]       r_cnt;
  logic [4:0]       r_dy;
  logic [2:0]       r_i;
  logic [63:0]      r_cur [0:BLK-1];
  logic [8*WIN-1:0] r_rowbuf;
  logic [SAD_W-1:0] r_acc [0:NPOS-1];
  logic [SAD_W-1:0] r_best;
  logic [4:0]       r_best_row;
  logic [4:0]       r_best_col;
  logic             r_pending;
  logic [SAD_W-1:0] r_msad;
  logic [4:0]       r_msad_row;
  logic [4:0]       r_msad_col;
  logic             r_valid;

  logic [10:0]      w_row_sad [0:NPOS-1];
  logic [63:0]      w_cur_row;
  logic [4:0]       w_ref_row;
  logic             w_cur_en;
  logic             w_ref_en;
  logic [SAD_W-1:0] w_min;
  logic [4:0]       w_min_col;

  assign w_cur_row = r_cur[r_i];
  assign w_ref_row = r_dy + {2'b00, r_i};
  assign w_cur_en  = (r_state == S_LOAD_CUR);
  assign w_ref_en  = (r_state == S_FETCH);

  assign bus.cur_mem_en   = w_cur_en;
  assign bus.ref_mem_en   = w_ref_en;
  assign bus.cur_mem_addr = w_cur_en ? cur_addr(r_cnt[3:1], r_cnt[0]) : 32'd0;
  assign bus.ref_mem_addr = w_ref_en ? ref_addr(w_ref_row, r_cnt[1:0]) : 32'd0;
  assign bus.MSAD         = r_msad;
  assign bus.MSAD_row     = r_msad_row;
  assign bus.MSAD_column  = r_msad_col;
  assign bus.data_valid   = r_valid;

  generate
    for (genvar g = 0; g < NPOS; g++) begin : g_pos
      sad_row8 u_sad (
        .i_cur (w_cur_row),
        .i_ref (r_rowbuf[8*g +: 64]),
        .o_sad (w_row_sad[g])
      );
    end
  endgenerate

  // Strict less-than keeps the lowest dx on ties.
  always_comb begin
    w_min     = r_acc[0];
    w_min_col = 5'd0;
    for (int k = 1; k < NPOS; k++) begin
      if (r_acc[k] < w_min) begin
        w_min     = r_acc[k];
        w_min_col = 5'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dy       <= '0;
      r_i        <= '0;
      r_rowbuf   <= '0;
      r_best     <= '0;
      r_best_row <= '0;
      r_best_col <= '0;
      r_pending  <= 1'b0;
      r_msad     <= '0;
      r_msad_row <= '0;
      r_msad_col <= '0;
      r_valid    <= 1'b0;
      for (int k = 0; k < BLK; k++) r_cur[k] <= '0;
      for (int k = 0; k < NPOS; k++) r_acc[k] <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.en_i) begin
            r_state    <= S_LOAD_CUR;
            r_cnt      <= '0;
            r_dy       <= '0;
            r_i        <= '0;
            r_best     <= SAD_INIT;
            r_best_row <= '0;
            r_best_col <= '0;
            for (int k = 0; k < NPOS; k++) r_acc[k] <= '0;
          end
        end
        S_LOAD_CUR: begin
          r_cur[r_cnt[3:1]][{r_cnt[0], 5'd0} +: 32] <= bus.cur_in_i;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end
        end
        S_FETCH: begin
          r_rowbuf[{r_cnt[1:0], 6'd0} +: 64] <= bus.ref_in_i;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt[1:0] == 2'd3) begin
            r_state <= S_ACC;
            r_cnt   <= '0;
          end
        end
        S_ACC: begin
          for (int k = 0; k < NPOS; k++) r_acc[k] <= r_acc[k] + {3'b000, w_row_sad[k]};
          if (r_i == 3'd7) begin
            r_i     <= '0;
            r_state <= S_CMP;
          end else begin
            r_i     <= r_i + 3'd1;
            r_state <= S_FETCH;
          end
        end
        S_CMP: begin
          if (w_min < r_best) begin
            r_best     <= w_min;
            r_best_row <= r_dy;
            r_best_col <= w_min_col;
          end
          for (int k = 0; k < NPOS; k++) r_acc[k] <= '0;
          if (r_dy == 5'(NPOS - 1)) begin
            r_state   <= S_DONE;
            r_pending <= 1'b1;
          end else begin
            r_dy    <= r_dy + 5'd1;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          // Publish once on entry; stay here until the start request is released.
          if (r_pending) begin
            r_msad     <= r_best;
            r_msad_row <= r_best_row;
            r_msad_col <= r_best_col;
            r_valid    <= 1'b1;
            r_pending  <= 1'b0;
          end
          if (!bus.en_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_me_unit.sv
// tb_me_unit -- directed self-checking bench for me_unit with combinational memory models.
// Rev 1.0
`default_nettype none

module tb_me_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  me_unit_if bus();

  me_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  cur_pix [0:63];
  logic [7:0]  ref_pix [0:1023];
  logic [31:0] cur_word;
  logic [63:0] ref_word;

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < 4; k++)
      cur_word[8*k +: 8] = cur_pix[4*int'(bus.cur_mem_addr[3:0]) + k];
  end

  always_comb begin
    ref_word = '0;
    for (int k = 0; k < 8; k++)
      ref_word[8*k +: 8] = ref_pix[8*int'(bus.ref_mem_addr[6:0]) + k];
  end

  assign bus.cur_in_i = cur_word;
  assign bus.ref_in_i = ref_word;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pulses = 0;
  logic [31:0] max_cur  = '0;
  logic [31:0] max_ref  = '0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) n_pulses++;
    if (bus.cur_mem_addr > max_cur) max_cur = bus.cur_mem_addr;
    if (bus.ref_mem_addr > max_ref) max_ref = bus.ref_mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic fill_match();
    for (int p = 0; p < 1024; p++) ref_pix[p] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        cur_pix[8*i + j] = ref_pix[(5 + i)*32 + 7 + j];
  endtask

  task automatic fill_const(input logic [7:0] c, input logic [7:0] r);
    for (int p = 0; p < 64; p++)   cur_pix[p] = c;
    for (int p = 0; p < 1024; p++) ref_pix[p] = r;
  endtask

  // Called at a negedge with the DUT idle; leaves en_i high.
  task automatic run_search(input string tag, input logic [31:0] e_msad,
                            input logic [31:0] e_row, input logic [31:0] e_col);
    int n;
    n = 0;
    bus.en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".cur_en0"}, 32'(bus.cur_mem_en), 32'd1);
    check({tag, ".cur_addr0"}, bus.cur_mem_addr, 32'd0);
    while (n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 16) begin
        check({tag, ".ref_en16"}, 32'(bus.ref_mem_en), 32'd1);
        check({tag, ".cur_en16"}, 32'(bus.cur_mem_en), 32'd0);
        check({tag, ".ref_addr16"}, bus.ref_mem_addr, 32'd0);
      end
      if (n == 21) check({tag, ".ref_addr21"}, bus.ref_mem_addr, 32'd4);
      if (bus.data_valid === 1'b1) break;
    end
    check({tag, ".latency"}, 32'(n), 32'd1042);
    check({tag, ".msad"}, 32'(bus.MSAD), e_msad);
    check({tag, ".row"}, 32'(bus.MSAD_row), e_row);
    check({tag, ".col"}, 32'(bus.MSAD_column), e_col);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".pulse_end"}, 32'(bus.data_valid), 32'd0);
  endtask

  int pulses_before;

  initial begin
    rst      = 1'b0;
    bus.en_i = 1'b0;
    fill_const(8'h00, 8'h00);
    repeat (3) @(negedge clk);

    check("rst.msad", 32'(bus.MSAD), 32'd0);
    check("rst.row", 32'(bus.MSAD_row), 32'd0);
    check("rst.col", 32'(bus.MSAD_column), 32'd0);
    check("rst.valid", 32'(bus.data_valid), 32'd0);
    check("rst.cur_en", 32'(bus.cur_mem_en), 32'd0);
    check("rst.ref_en", 32'(bus.ref_mem_en), 32'd0);
    check("rst.cur_addr", bus.cur_mem_addr, 32'd0);
    check("rst.ref_addr", bus.ref_mem_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Exact copy at (5,7); en_i held high ~3000 cycles.
    fill_match();
    run_search("match", 32'd0, 32'd5, 32'd7);
    repeat (3000 - 1044) @(negedge clk);
    check("hold.pulses", 32'(n_pulses), 32'd1);
    check("hold.row", 32'(bus.MSAD_row), 32'd5);
    check("hold.col", 32'(bus.MSAD_column), 32'd7);
    check("max.cur_addr", max_cur, 32'd15);
    check("max.ref_addr", max_ref, 32'd127);
    bus.en_i = 1'b0;
    repeat (3) @(negedge clk);

    run_search("rerun", 32'd0, 32'd5, 32'd7);
    bus.en_i = 1'b0;
    repeat (3) @(negedge clk);

    fill_const(8'h00, 8'h00);
    run_search("zero", 32'd0, 32'd0, 32'd0);
    bus.en_i = 1'b0;
    repeat (3) @(negedge clk);

    fill_const(8'hFF, 8'h00);
    run_search("maxsad", 32'd16320, 32'd0, 32'd0);
    bus.en_i = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during the third fetch word of dy=10, block row 0.
    fill_match();
    bus.en_i = 1'b1;
    @(posedge clk);
    repeat (428) @(posedge clk);
    @(negedge clk);
    check("abort.ref_en", 32'(bus.ref_mem_en), 32'd1);
    check("abort.ref_addr", bus.ref_mem_addr, 32'd42);
    pulses_before = n_pulses;
    rst = 1'b0;
    #1;
    check("abort.msad", 32'(bus.MSAD), 32'd0);
    check("abort.row", 32'(bus.MSAD_row), 32'd0);
    check("abort.col", 32'(bus.MSAD_column), 32'd0);
    check("abort.valid", 32'(bus.data_valid), 32'd0);
    check("abort.ref_en0", 32'(bus.ref_mem_en), 32'd0);
    check("abort.ref_addr0", bus.ref_mem_addr, 32'd0);
    bus.en_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("abort.no_pulse", 32'(n_pulses), 32'(pulses_before));

    run_search("restart", 32'd0, 32'd5, 32'd7);
    bus.en_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/me_unit.md
ME_UNIT -- requirements
Module: me_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 en_i  in  1  start request, level-sensitive.
REQ-004 cur_in_i  in  32  current-block word, 4 pixels of 8 bits, leftmost pixel in [7:0].
REQ-005 ref_in_i  in  64  reference-window word, 8 pixels of 8 bits, leftmost pixel in [7:0].
REQ-006 cur_mem_addr  out  32  current-block word address; address = 2*row + half; half 0 = columns 0..3; bits [31:4] always 0.
REQ-007 ref_mem_addr  out  32  reference word address; address = 4*row + w; word w = columns 8w..8w+7; bits [31:7] always 0.
REQ-008 cur_mem_en / ref_mem_en  out  1 each  read strobes; high only in cycles that capture data.
REQ-009 MSAD  out  14  minimum sum of absolute differences.
REQ-010 MSAD_row / MSAD_column  out  5 each  vertical/horizontal offset of the best match, 0..24.
REQ-011 data_valid  out  1  one-cycle pulse marking a final result.
REQ-012 Memories are combinational: read data is valid in the same cycle as address and enable; the block captures data on the next rising edge.

Function
REQ-013 Current block: 8x8 pixels (16 words); reference window: 32x32 pixels (128 words); candidate positions (dy,dx), dy,dx in 0..24 (625 candidates).
REQ-014 SAD(dy,dx) = sum over i,j in 0..7 of |cur[i][j] - ref[dy+i][dx+j]|, unsigned; maximum 16320, fits 14 bits without overflow.
REQ-015 States: IDLE, LOAD_CUR, FETCH, ACC, CMP, DONE.
REQ-016 IDLE -> LOAD_CUR on an edge sampling en_i=1; otherwise stay.
REQ-017 LOAD_CUR: 16 cycles, cur_mem_en=1, addresses 0..15 in order, each word stored into an internal 8x8 pixel array.
REQ-018 For each dy = 0..24 and each block row i = 0..7: FETCH 4 cycles with ref_mem_en=1 and addresses 4*(dy+i)+0..3, filling a 32-pixel row buffer; then 1 ACC cycle adding each of 25 row partial sums (buffer columns dx..dx+7 vs cur row i) into 25 accumulators.
REQ-019 Accumulators clear at the start of every dy; after i=7 one CMP cycle runs per dy.
REQ-020 CMP: pick the smallest of the 25 sums (lowest dx on ties); replace the best result only if strictly less than the stored best; the stored best initialises to 16383 on start.
REQ-021 Tie rule overall: the first minimum in row-major scan order (dy, then dx) wins.
REQ-022 After CMP for dy=24: enter DONE, MSAD/MSAD_row/MSAD_column registered, data_valid high for exactly one cycle.
REQ-023 Latency: data_valid is high in the cycle after the 1042nd rising edge following the start edge (16 + 25*41 + 1).
REQ-024 DONE -> IDLE only when en_i=0; holding en_i high produces exactly one result; result outputs hold until the next start.
REQ-025 en_i dropping mid-search has no effect; the search completes.

Reset
REQ-026 While rst=0: state IDLE, all counters 0, MSAD=0, MSAD_row=0, MSAD_column=0, data_valid=0, both enables 0, both addresses 0.
REQ-027 Reset asserted mid-search aborts immediately; no data_valid is produced for the aborted search.

Structure
REQ-028 A shared package holds BLK=8, WIN=32, NPOS=25, SAD_W=14, address formulas and the state enumeration.
REQ-029 One sub-module, sad_row8: combinational sum of 8 absolute pixel differences (11-bit result), instantiated 25 times.
REQ-030 cur_mem and ref_mem are separate combinational memory models outside me_unit.

Verification
REQ-031 Cur block = ref window copied at (dy=5,dx=7), the rest of the window random nonzero-mismatched -> single pulse: MSAD=0, row=5, column=7.
REQ-032 Both memories all zero -> MSAD=0 at (0,0) (tie rule).
REQ-033 Cur all 0xFF, ref all 0x00 -> MSAD=16320 at (0,0).
REQ-034 en_i held high for 3000 cycles -> exactly one data_valid pulse, at the cycle given by REQ-023; addresses never exceed 15 / 127.
REQ-035 rst pulsed low during FETCH at dy=10 -> all outputs 0 immediately; a new start yields a correct result with full latency.
REQ-036 en_i low then high after DONE -> second search with identical result.
